// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//   MEM-stage data-memory access unit. Takes the load/store held in the M
//   stage, issues one request on a valid/ready bus to a multi-cycle memory,
//   stalls the pipeline until the access completes, and returns size/sign
//   adjusted load data. Misaligned or illegal-size accesses complete with
//   memfault set and never reach the bus.
//
// Handshake: a request transfers on a rising edge where bus_valid && bus_ready
//   are both 1. While bus_valid is 1 the payload (bus_we, bus_addr, bus_wdata,
//   bus_wstrb) is held stable and bus_valid is not withdrawn until accepted.
//   Read data is taken on the first bus_rvalid after acceptance; bus_rvalid
//   is ignored at any other time.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   memreqM, memwriteM  M-stage memory instruction present / is a store
//   funct3M, addrM      size/sign code, byte address
//   wdataM              low-aligned store data
//   stallMem            hold F/D/E/M this cycle (combinational)
//   rdataM, memfault    load result / fault flag, updated when DONE is entered
//   bus_*               registered request bus and read-return inputs
//   dbgState            current FSM state (IDLE=0, REQ=1, WAIT_R=2, DONE=3)
module dmem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memreqM,
  input  logic              memwriteM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] wdataM,
  output logic              stallMem,
  output logic [DATA_W-1:0] rdataM,
  output logic              memfault,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_R = 2'd2, DONE = 2'd3} state_t;

  state_t            state, stateNext;
  logic [2:0]        funct3Q;    // size/sign of the access in flight
  logic [1:0]        offQ;       // byte offset of the access in flight
  logic              sizeOk, aligned, accessOk;
  logic [3:0]        wstrbNext;
  logic [DATA_W-1:0] wdataNext;
  logic [DATA_W-1:0] loadData;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;

  assign dbgState = state;

  // In DONE the pipeline advances so the finished instruction leaves M.
  assign stallMem = memreqM && (state != DONE);

  // Legality of the M-stage access: unsigned loads have no store form.
  always_comb begin
    sizeOk  = 1'b0;
    aligned = 1'b0;
    case (funct3M)
      3'b000: begin sizeOk = 1'b1;       aligned = 1'b1;             end
      3'b001: begin sizeOk = 1'b1;       aligned = ~addrM[0];        end
      3'b010: begin sizeOk = 1'b1;       aligned = (addrM[1:0] == 2'b00); end
      3'b100: begin sizeOk = ~memwriteM; aligned = 1'b1;             end
      3'b101: begin sizeOk = ~memwriteM; aligned = ~addrM[0];        end
      default: begin sizeOk = 1'b0;      aligned = 1'b0;             end
    endcase
    accessOk = sizeOk && aligned;
  end

  // Store lanes: data is replicated so the memory only needs the strobes.
  always_comb begin
    wstrbNext = 4'b0000;
    wdataNext = wdataM;
    case (funct3M[1:0])
      2'b00: begin
        wstrbNext = 4'b0001 << addrM[1:0];
        wdataNext = {4{wdataM[7:0]}};
      end
      2'b01: begin
        wstrbNext = addrM[1] ? 4'b1100 : 4'b0011;
        wdataNext = {2{wdataM[15:0]}};
      end
      default: wstrbNext = 4'b1111;
    endcase
    if (!memwriteM) wstrbNext = 4'b0000;
  end

  // Load extract from the returned word using the latched offset and size.
  always_comb begin
    case (offQ)
      2'd0:    byteSel = bus_rdata[7:0];
      2'd1:    byteSel = bus_rdata[15:8];
      2'd2:    byteSel = bus_rdata[23:16];
      default: byteSel = bus_rdata[31:24];
    endcase
    halfSel = offQ[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3Q)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadData = {24'd0, byteSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = bus_rdata;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (memreqM) stateNext = accessOk ? REQ : DONE;
      REQ:     if (bus_ready) stateNext = bus_we ? DONE : WAIT_R;
      WAIT_R:  if (bus_rvalid) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Registered bus payload and results. The payload is captured once in
  // IDLE and left untouched afterwards, which keeps it stable through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= 4'b0000;
      rdataM    <= '0;
      memfault  <= 1'b0;
      funct3Q   <= 3'b000;
      offQ      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (memreqM && accessOk) begin
            bus_valid <= 1'b1;
            bus_we    <= memwriteM;
            bus_addr  <= {addrM[ADDR_W-1:2], 2'b00};
            bus_wdata <= wdataNext;
            bus_wstrb <= wstrbNext;
            funct3Q   <= funct3M;
            offQ      <= addrM[1:0];
          end else if (memreqM) begin
            memfault <= 1'b1;
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (bus_we) memfault <= 1'b0;
          end
        end
        WAIT_R: begin
          if (bus_rvalid) begin
            rdataM   <= loadData;
            memfault <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memreqM, memwriteM;
  logic [2:0]  funct3M;
  logic [31:0] addrM, wdataM;
  logic        stallMem;
  logic [31:0] rdataM;
  logic        memfault;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic [1:0]  dbgState;

  int checks = 0;
  int errors = 0;

  dmem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .memreqM(memreqM), .memwriteM(memwriteM),
    .funct3M(funct3M), .addrM(addrM), .wdataM(wdataM), .stallMem(stallMem),
    .rdataM(rdataM), .memfault(memfault), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .dbgState(dbgState)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // reference model: RISC-V load/store rules in plain arithmetic
  function automatic bit exp_fault(input logic [2:0] f3, input bit we, input logic [31:0] a);
    int unsigned size;
    bit legal;
    legal = (f3 <= 3'd2) || ((f3 == 3'd4 || f3 == 3'd5) && !we);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return !legal || ((a % size) != 0);
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input bit we, input logic [31:0] a);
    if (!we) return 4'b0000;
    if (f3 == 3'd0) return 4'(1 << (a % 4));
    if (f3 == 3'd1) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] b, h;
    b = w & 32'hFF;
    h = w & 32'hFFFF;
    if (f3 == 3'd0) return b * 32'h01010101;
    if (f3 == 3'd1) return h * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * (a % 4))) & 32'hFF;
    h = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  // driver: one M-stage access, acting as the memory with rw wait cycles on
  // bus_ready and vw extra cycles before bus_rvalid
  task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int rw, input int vw);
    int stalls = 0;
    int nValid = 0;
    int acceptCyc = -1;
    bit done = 0;
    bit flt;
    int expStall;
    flt = exp_fault(f3, we, addr);
    @(negedge clk);
    memreqM = 1'b1; memwriteM = we; funct3M = f3; addrM = addr; wdataM = wd;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (!stallMem) begin done = 1; break; end
      stalls++;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (bus_valid) begin
        nValid++;
        chk("bus_addr", bus_addr, addr & 32'hFFFFFFFC);
        chk("bus_we", 32'(bus_we), 32'(we));
        chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb(f3, we, addr)));
        if (we) chk("bus_wdata", bus_wdata, exp_wdata(f3, wd));
        if (nValid > rw) begin bus_ready = 1'b1; acceptCyc = cyc; end
      end else if (acceptCyc >= 0 && !we && (cyc - acceptCyc) > vw) begin
        bus_rvalid = 1'b1; bus_rdata = rd;
      end
      @(negedge clk);
    end
    chk("done_reached", 32'(done), 32'd1);
    if (done) begin
      expStall = flt ? 1 : (we ? 2 + rw : 3 + rw + vw);
      chk("stall_cycles", stalls, expStall);
      chk("valid_cycles", nValid, flt ? 0 : rw + 1);
      chk("state_done", 32'(dbgState), 32'd3);
      chk("memfault", 32'(memfault), 32'(flt));
      if (!flt && !we) chk("rdataM", rdataM, exp_load(f3, addr, rd));
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      memreqM = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
      #1 chk("idle_stall", 32'(stallMem), 32'd0);
    end
  endtask

  logic [2:0] legalF3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a;
    // reset state
    rst_n = 1'b0; memreqM = 1'b0; memwriteM = 1'b0; funct3M = 3'd0; addrM = '0;
    wdataM = '0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    #12;
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_rdataM", rdataM, 32'd0);
    chk("rst_memfault", 32'(memfault), 32'd0);
    chk("rst_state", 32'(dbgState), 32'd0);
    chk("rst_stall_lo", 32'(stallMem), 32'd0);
    memreqM = 1'b1; #1;
    chk("rst_stall_hi", 32'(stallMem), 32'd1);
    memreqM = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // directed loads
    do_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    do_access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, 0);
    do_access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 0, 0);
    do_access(1'b0, 3'd1, 32'h102, 32'h0, 32'h80112233, 0, 1);
    chk("lh_value", rdataM, 32'hFFFF8011);
    // directed stores
    do_access(1'b1, 3'd0, 32'h201, 32'h000000A5, 32'h0, 0, 0);
    do_access(1'b1, 3'd1, 32'h202, 32'h00001234, 32'h0, 3, 0);
    // misaligned LW
    do_access(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0);
    // illegal: unsigned store and funct3 011
    do_access(1'b1, 3'd4, 32'h104, 32'h55, 32'h0, 0, 0);
    do_access(1'b0, 3'd3, 32'h108, 32'h0, 32'h0, 0, 0);
    idle(1);

    // reset while in WAIT_R
    @(negedge clk);
    memreqM = 1'b1; memwriteM = 1'b0; funct3M = 3'd2; addrM = 32'h300;
    @(negedge clk); bus_ready = 1'b1;
    @(negedge clk); bus_ready = 1'b0;
    #1 chk("wr_state", 32'(dbgState), 32'd2);
    rst_n = 1'b0; #1;
    chk("rstmid_valid", 32'(bus_valid), 32'd0);
    chk("rstmid_state", 32'(dbgState), 32'd0);
    chk("rstmid_stall", 32'(stallMem), 32'd1);
    @(negedge clk); rst_n = 1'b1; memreqM = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk); bus_rvalid = 1'b0;
    #1;
    chk("stray_state", 32'(dbgState), 32'd0);
    chk("stray_rdata", rdataM, 32'd0);
    chk("stray_valid", 32'(bus_valid), 32'd0);
    do_access(1'b0, 3'd2, 32'h304, 32'h0, 32'hCAFEF00D, 0, 0);

    // back-to-back LWs with wait states on bus_ready
    do_access(1'b0, 3'd2, 32'h400, 32'h0, 32'h11112222, 2, 0);
    do_access(1'b0, 3'd2, 32'h404, 32'h0, 32'h33334444, 2, 1);

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legalF3[$urandom_range(0, 4)];
      a  = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 9) < 7) a = a & ~32'(f3[1:0] == 2'd0 ? 0 : (f3[1:0] == 2'd1 ? 1 : 3));
      do_access(we, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
